// File: rtl/mux.sv
// mux: 8-to-1 single-bit selector with a registered copy of the selected bit,
// 0->1 / 1->0 edge pulses and a saturating count of registered-bit changes.
// y and sel_oh are purely combinational and stay valid during reset.
module mux #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       a,
   input  logic [2:0]       s,
   input  logic             en,
   input  logic             clr,
   output logic             y,
   output logic [7:0]       sel_oh,
   output logic             y_q,
   output logic             y_rise,
   output logic             y_fall,
   output logic [CNT_W-1:0] tog_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [7:0]       pick;
   logic             y_q_reg,    y_q_next;
   logic             y_rise_reg, y_rise_next;
   logic             y_fall_reg, y_fall_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;

   // One decoder lane per candidate bit: lane gi is hot when s selects it,
   // and the same lane gates a[gi] so the selected bit is an OR of the lanes.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign sel_oh[gi] = (s == 3'(gi));
         assign pick[gi]   = a[gi] & sel_oh[gi];
      end
   endgenerate

   assign y = |pick;

   // Next-state for the registered path: capture, edge pulses and counter.
   always_comb begin
      y_q_next    = y_q_reg;
      y_rise_next = 1'b0;
      y_fall_next = 1'b0;
      cnt_next    = cnt_reg;
      if (en) begin
         y_q_next    = y;
         y_rise_next = y & ~y_q_reg;
         y_fall_next = ~y & y_q_reg;
         if ((y != y_q_reg) && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
      // Clear wins over any increment on the same edge, enabled or not.
      if (clr) begin
         cnt_next = '0;
      end
   end

   // State registers with synchronous active-low reset dominating en and clr.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q_reg    <= 1'b0;
         y_rise_reg <= 1'b0;
         y_fall_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         y_q_reg    <= y_q_next;
         y_rise_reg <= y_rise_next;
         y_fall_reg <= y_fall_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign y_q     = y_q_reg;
   assign y_rise  = y_rise_reg;
   assign y_fall  = y_fall_reg;
   assign tog_cnt = cnt_reg;

endmodule

// File: tb/tb_mux.sv
// tb_mux: randomized and directed checks of mux against a behavioural model.
// Two instances share the inputs: default 8-bit counter and a 2-bit counter
// for saturation.
module tb_mux;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [2:0] s;
   logic       en;
   logic       clr;

   logic       y,  y_q,  y_rise,  y_fall;
   logic [7:0] sel_oh;
   logic [7:0] tog_cnt;
   logic       y2, y_q2, y_rise2, y_fall2;
   logic [7:0] sel_oh2;
   logic [1:0] tog_cnt2;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_yq   = 0;
   int m_rise = 0;
   int m_fall = 0;
   int m_cnt  = 0;
   int m_cnt2 = 0;

   mux #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .s(s), .en(en), .clr(clr),
      .y(y), .sel_oh(sel_oh), .y_q(y_q), .y_rise(y_rise), .y_fall(y_fall),
      .tog_cnt(tog_cnt)
   );

   mux #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .a(a), .s(s), .en(en), .clr(clr),
      .y(y2), .sel_oh(sel_oh2), .y_q(y_q2), .y_rise(y_rise2), .y_fall(y_fall2),
      .tog_cnt(tog_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: selected bit by shifting, counters as capped integers.
   always @(posedge clk) begin
      int sel;
      sel = (int'(a) >> int'(s)) & 1;
      if (!rst_n) begin
         m_yq <= 0; m_rise <= 0; m_fall <= 0; m_cnt <= 0; m_cnt2 <= 0;
      end else begin
         int c1, c2;
         c1 = m_cnt;
         c2 = m_cnt2;
         if (en) begin
            if (sel != m_yq) begin
               c1 = (c1 + 1 > 255) ? 255 : c1 + 1;
               c2 = (c2 + 1 > 3)   ? 3   : c2 + 1;
            end
            m_rise <= (sel == 1 && m_yq == 0) ? 1 : 0;
            m_fall <= (sel == 0 && m_yq == 1) ? 1 : 0;
            m_yq   <= sel;
         end else begin
            m_rise <= 0;
            m_fall <= 0;
         end
         if (clr) begin
            c1 = 0;
            c2 = 0;
         end
         m_cnt  <= c1;
         m_cnt2 <= c2;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_comb();
      check("y",       int'(y),       (int'(a) >> int'(s)) & 1);
      check("sel_oh",  int'(sel_oh),  1 << int'(s));
      check("y2",      int'(y2),      (int'(a) >> int'(s)) & 1);
      check("sel_oh2", int'(sel_oh2), 1 << int'(s));
   endtask

   task automatic check_regs();
      check("y_q",      int'(y_q),      m_yq);
      check("y_rise",   int'(y_rise),   m_rise);
      check("y_fall",   int'(y_fall),   m_fall);
      check("tog_cnt",  int'(tog_cnt),  m_cnt);
      check("y_q2",     int'(y_q2),     m_yq);
      check("tog_cnt2", int'(tog_cnt2), m_cnt2);
      check("pulse_excl", int'(y_rise & y_fall), 0);
   endtask

   // Advance one edge, then sample 1 ns after it and print the transaction.
   task automatic tick();
      @(posedge clk);
      #1;
      $display("t=%0t rst_n=%0b en=%0b clr=%0b a=%02h s=%0d y=%0b y_q=%0b rise=%0b fall=%0b cnt=%0d cnt2=%0d",
               $time, rst_n, en, clr, a, s, y, y_q, y_rise, y_fall, tog_cnt, tog_cnt2);
      check_regs();
      check_comb();
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] y_tab;
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 8'h00; s = 3'd0;
      pat   = 8'b1010_0101;
      y_tab = 8'b1010_0101;

      // Exhaustive combinational sweep
      a = pat;
      for (int i = 0; i < 8; i++) begin
         s = 3'(i);
         #1;
         $display("comb a=%02h s=%0d y=%0b sel_oh=%02h", a, s, y, sel_oh);
         check("comb_y",      int'(y),      int'(y_tab[i]));
         check("comb_sel_oh", int'(sel_oh), 1 << i);
      end

      // Random selection, 10 ns hold each
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom);
         s = 3'($urandom % 8);
         #10;
         $display("rand a=%02h s=%0d y=%0b", a, s, y);
         check_comb();
      end

      // Reset held for two edges with a=FF, en=1
      @(negedge clk);
      a = 8'hFF; en = 1'b1; rst_n = 1'b0;
      tick();
      tick();
      check("rst_y_q", int'(y_q), 0);
      check("rst_cnt", int'(tog_cnt), 0);
      check("rst_y",   int'(y), 1);

      // Release: first enabled edge sees a[s]=1 against y_q=0
      rst_n = 1'b1;
      tick();
      check("rel_y_q",  int'(y_q), 1);
      check("rel_rise", int'(y_rise), 1);
      check("rel_cnt",  int'(tog_cnt), 1);

      // Toggle a[3] with s=3
      s = 3'd3;
      a[3] = 1'b0; tick();
      check("tog_fall", int'(y_fall), 1);
      a[3] = 1'b1; tick();
      check("tog_rise", int'(y_rise), 1);
      check("tog_cnt3", int'(tog_cnt), 3);

      // Enable low: counter holds, pulses drop
      en = 1'b0;
      a[3] = 1'b0; tick();
      a[3] = 1'b1; tick();
      check("hold_cnt", int'(tog_cnt), 3);
      check("hold_rise", int'(y_rise), 0);

      // Saturation of the 2-bit counter
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a[3] = ~a[3];
         tick();
      end
      check("sat_cnt2", int'(tog_cnt2), 3);
      tick();
      check("sat_hold2", int'(tog_cnt2), 3);

      // Clear on a toggling edge
      clr = 1'b1;
      a[3] = ~a[3];
      tick();
      check("clr_cnt",  int'(tog_cnt), 0);
      check("clr_y_q",  int'(y_q), int'(a[3]));
      clr = 1'b0;

      // Randomized run with occasional clear and reset
      for (int i = 0; i < 300; i++) begin
         a     = 8'($urandom);
         s     = 3'($urandom_range(0, 7));
         en    = ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 19) == 0);
         rst_n = ($urandom_range(0, 39) != 0);
         tick();
      end

      // Bias toward repeated toggling of one bit to exercise the 8-bit limit
      rst_n = 1'b1; clr = 1'b0; en = 1'b1; s = 3'd5;
      for (int i = 0; i < 270; i++) begin
         a[5] = ~a[5];
         tick();
      end
      check("sat_cnt8", int'(tog_cnt), 255);

      // Mid-operation reset
      rst_n = 1'b0;
      tick();
      check("mid_rst_cnt", int'(tog_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux.md
# mux

Eight-to-one single-bit selector: output `y` follows data bit `a[s]` combinationally. Also provides a registered copy of the selected bit, edge-detect pulses and a saturating toggle counter. It sits in datapath glue logic wherever one bit of an 8-bit bus must be picked by a 3-bit index and optionally observed synchronously.

## Interface
Parameters:
- `CNT_W`, default 8: width of the toggle counter.

Ports:
- `clk`  input  1  single clock; all registers update on rising edge.
- `rst_n`  input  1  reset; synchronous and active-low.
- `a`  input  8  data bus; bit i is candidate i.
- `s`  input  3  select index, 0..7.
- `en`  input  1  capture enable for the registered path.
- `clr`  input  1  synchronous clear of the toggle counter.
- `y`  output  1  combinational selected bit, `a[s]`.
- `sel_oh`  output  8  combinational one-hot decode of `s` (bit s set).
- `y_q`  output  1  registered selected bit.
- `y_rise`  output  1  one-cycle pulse: registered bit went 0→1.
- `y_fall`  output  1  one-cycle pulse: registered bit went 1→0.
- `tog_cnt`  output  CNT_W  count of `y_q` changes, saturating.

## Operation
- `y = a[s]` for every value of `s`. Purely combinational, no clock dependency, valid during reset.
- `sel_oh = 8'b1 << s`. Combinational, exactly one bit is always set.
- Registered path, on each rising `clk` with `rst_n`=1 and `en`=1:
  - `y_q` ← `a[s]`.
  - `y_rise` ← `a[s] & ~y_q`.
  - `y_fall` ← `~a[s] & y_q`.
  - If `a[s] != y_q`, `tog_cnt` increments by 1, saturating at 2^CNT_W−1.
- With `en`=0:
  - `y_q` and `tog_cnt` hold.
  - `y_rise` and `y_fall` are forced to 0.
- `clr`=1 (with `rst_n`=1): `tog_cnt` ← 0 on the edge, overriding any increment on that edge. `y_q` and the pulses still update normally.
- `y_rise` and `y_fall` are never both 1.

## Timing
- Reset: while `rst_n`=0 at a rising edge, `y_q`=0, `y_rise`=0, `y_fall`=0 and `tog_cnt`=0. Reset dominates `en` and `clr`.
- `y` and `sel_oh` have zero-cycle latency and settle within the same delta as a change on `a` or `s`.
- `y_q` latency is 1 cycle from the `a`/`s` sample.
- Edge pulses assert in the same cycle `y_q` changes and last exactly 1 cycle, unless the bit toggles again on the next enabled edge.
- First enabled edge after reset with `a[s]`=1: `y_rise`=1 and `tog_cnt`=1, because `y_q` resets to 0.
- Reset asserted mid-operation clears all registers on the next edge. Combinational outputs are unaffected.

## Test plan
- Exhaustive combinational check, no clock edges:
  - `a`=8'b1010_0101, `s`=0..7 → `y`=1,0,1,0,0,1,0,1.
  - `sel_oh`=8'h01,02,04,08,10,20,40,80.
- Random stimulus: 10 pairs of random `a` and `s`=$random%8, held 10 ns each → `y` == `a[s]` every time.
- Reset:
  - Hold `rst_n`=0 for 2 edges with `a`=8'hFF, `en`=1 → `y_q`=0, pulses 0, `tog_cnt`=0, while `y`=1.
  - Release `rst_n` → next edge gives `y_q`=1, `y_rise`=1, `tog_cnt`=1.
- Edge pulses and enable:
  - With `en`=1, `s`=3, toggle `a[3]` 1,0,1 on successive edges → `y_rise`/`y_fall` alternate and `tog_cnt` reaches 3.
  - Drop `en` → `tog_cnt` holds at 3 and pulses go to 0.
- Saturation and clear:
  - With `CNT_W`=2, toggle 5 times → `tog_cnt`=3 and stays there.
  - Assert `clr` on an edge where the bit toggles → `tog_cnt`=0 and `y_q` still updates.
